// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with data-bus load/store unit (req/ack handshake, lane alignment).
// Optional feature macro MEM_UNALIGNED_EXC_EN: trap misaligned half/word accesses instead of issuing them.
module mem_stage_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_Valid,
  input  logic [31:0] EX_AluOut,
  input  logic [31:0] EX_StoreData,
  input  logic        EX_MemRd,
  input  logic        EX_MemWr,
  input  logic [1:0]  EX_LsSize,
  input  logic        EX_LoadSigned,
  input  logic [29:0] EX_PcAddOne,
  input  logic [1:0]  EX_WbSel,
  input  logic [4:0]  EX_Rw,
  input  logic [31:0] EX_Instr,
  input  logic        EX_RfWr,
  output logic        MEM_Stall,
  output logic [31:0] MEM_AluOut,
  output logic [31:0] MEM_LTypeDmOut,
  output logic [29:0] MEM_PcAddOne,
  output logic [1:0]  MEM_WbSel,
  output logic [4:0]  MEM_Rw,
  output logic [31:0] MEM_Instr,
  output logic        MEM_RfWr,
  output logic        MEM_Exc,
  output logic        MEM_BusErr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned TMAX = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
  localparam int unsigned CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [1:0]    offHeld;
  logic [1:0]    sizeHeld;
  logic          signedHeld;
  logic          loadHeld;
  logic          rfWrHeld;

  logic          memOp;
  logic          misaligned;
  logic [1:0]    off;
  logic [3:0]    beNext;
  logic [31:0]   wdataNext;
  logic [7:0]    byteData;
  logic [15:0]   halfData;
  logic [31:0]   loadExt;

  assign off   = EX_AluOut[1:0];
  assign memOp = EX_Valid & (EX_MemRd | EX_MemWr);

`ifdef MEM_UNALIGNED_EXC_EN
  assign misaligned = (EX_LsSize == 2'b01) ? off[0] : (EX_LsSize[1] & (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    beNext    = 4'b1111;
    wdataNext = EX_StoreData;
    case (EX_LsSize)
      2'b00: begin
        beNext    = 4'b0001 << off;
        wdataNext = {4{EX_StoreData[7:0]}};
      end
      2'b01: begin
        beNext    = off[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{EX_StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the offset captured with the request, since dbus_addr is word-aligned.
  always_comb begin
    byteData = dbus_rdata[7:0];
    case (offHeld)
      2'b01:   byteData = dbus_rdata[15:8];
      2'b10:   byteData = dbus_rdata[23:16];
      2'b11:   byteData = dbus_rdata[31:24];
      default: ;
    endcase
    halfData = offHeld[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    loadExt  = dbus_rdata;
    case (sizeHeld)
      2'b00:   loadExt = {{24{signedHeld & byteData[7]}}, byteData};
      2'b01:   loadExt = {{16{signedHeld & halfData[15]}}, halfData};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      waitCnt        <= '0;
      offHeld        <= '0;
      sizeHeld       <= '0;
      signedHeld     <= 1'b0;
      loadHeld       <= 1'b0;
      rfWrHeld       <= 1'b0;
      MEM_Stall      <= 1'b0;
      MEM_AluOut     <= '0;
      MEM_LTypeDmOut <= '0;
      MEM_PcAddOne   <= '0;
      MEM_WbSel      <= '0;
      MEM_Rw         <= '0;
      MEM_Instr      <= '0;
      MEM_RfWr       <= 1'b0;
      MEM_Exc        <= 1'b0;
      MEM_BusErr     <= 1'b0;
      dbus_req       <= 1'b0;
      dbus_we        <= 1'b0;
      dbus_be        <= '0;
      dbus_addr      <= '0;
      dbus_wdata     <= '0;
    end else begin
      MEM_BusErr <= 1'b0;
      case (state)
        BUSY: begin
          if (dbus_ack) begin
            state     <= DONE;
            dbus_req  <= 1'b0;
            MEM_Stall <= 1'b0;
            MEM_RfWr  <= rfWrHeld;
            if (loadHeld) MEM_LTypeDmOut <= loadExt;
          end else if (BUS_TIMEOUT != 0 && waitCnt == CW'(TMAX)) begin
            state      <= DONE;
            dbus_req   <= 1'b0;
            MEM_Stall  <= 1'b0;
            MEM_BusErr <= 1'b1;
            MEM_RfWr   <= 1'b0;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: begin
          MEM_AluOut   <= EX_AluOut;
          MEM_PcAddOne <= EX_PcAddOne;
          MEM_WbSel    <= EX_WbSel;
          MEM_Rw       <= EX_Rw;
          MEM_Instr    <= EX_Instr;
          MEM_Exc      <= memOp & misaligned;
          if (memOp && !misaligned) begin
            state      <= BUSY;
            waitCnt    <= '0;
            dbus_req   <= 1'b1;
            MEM_Stall  <= 1'b1;
            MEM_RfWr   <= 1'b0;
            dbus_we    <= EX_MemWr;
            dbus_be    <= beNext;
            dbus_addr  <= {EX_AluOut[31:2], 2'b00};
            dbus_wdata <= wdataNext;
            offHeld    <= off;
            sizeHeld   <= EX_LsSize;
            signedHeld <= EX_LoadSigned;
            loadHeld   <= EX_MemRd & ~EX_MemWr;
            rfWrHeld   <= EX_RfWr;
          end else begin
            state    <= IDLE;
            MEM_RfWr <= EX_Valid & EX_RfWr & ~memOp;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed spec scenarios plus random instruction stream vs. arithmetic model.
module tb_mem_stage_lsu;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EX_Valid = 1'b0;
  logic [31:0] EX_AluOut = '0;
  logic [31:0] EX_StoreData = '0;
  logic        EX_MemRd = 1'b0;
  logic        EX_MemWr = 1'b0;
  logic [1:0]  EX_LsSize = '0;
  logic        EX_LoadSigned = 1'b0;
  logic [29:0] EX_PcAddOne = '0;
  logic [1:0]  EX_WbSel = '0;
  logic [4:0]  EX_Rw = '0;
  logic [31:0] EX_Instr = '0;
  logic        EX_RfWr = 1'b0;
  logic        MEM_Stall;
  logic [31:0] MEM_AluOut;
  logic [31:0] MEM_LTypeDmOut;
  logic [29:0] MEM_PcAddOne;
  logic [1:0]  MEM_WbSel;
  logic [4:0]  MEM_Rw;
  logic [31:0] MEM_Instr;
  logic        MEM_RfWr;
  logic        MEM_Exc;
  logic        MEM_BusErr;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_Valid(EX_Valid), .EX_AluOut(EX_AluOut), .EX_StoreData(EX_StoreData),
    .EX_MemRd(EX_MemRd), .EX_MemWr(EX_MemWr), .EX_LsSize(EX_LsSize),
    .EX_LoadSigned(EX_LoadSigned), .EX_PcAddOne(EX_PcAddOne), .EX_WbSel(EX_WbSel),
    .EX_Rw(EX_Rw), .EX_Instr(EX_Instr), .EX_RfWr(EX_RfWr),
    .MEM_Stall(MEM_Stall), .MEM_AluOut(MEM_AluOut), .MEM_LTypeDmOut(MEM_LTypeDmOut),
    .MEM_PcAddOne(MEM_PcAddOne), .MEM_WbSel(MEM_WbSel), .MEM_Rw(MEM_Rw),
    .MEM_Instr(MEM_Instr), .MEM_RfWr(MEM_RfWr), .MEM_Exc(MEM_Exc), .MEM_BusErr(MEM_BusErr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  typedef struct {
    logic        valid, rd, wr, sgn, rfwr, noAck;
    logic [1:0]  size, wb;
    logic [31:0] addr, data, instr, rdata;
    logic [29:0] pc;
    logic [4:0]  rw;
    int          waits;
  } instr_t;

  int          nCmp = 0;
  int          nMis = 0;
  logic [31:0] lastLoad = '0;
  instr_t      prog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t randInstr();
    instr_t t;
    int k;
    k       = $urandom_range(0, 2);
    t.valid = ($urandom_range(0, 7) != 0);
    t.rd    = (k == 1);
    t.wr    = (k == 2);
    t.sgn   = 1'($urandom_range(0, 1));
    t.rfwr  = 1'($urandom_range(0, 1));
    t.size  = 2'($urandom_range(0, 3));
    t.wb    = 2'($urandom_range(0, 3));
    t.addr  = $urandom;
    t.data  = $urandom;
    t.instr = $urandom;
    t.rdata = $urandom;
    t.pc    = 30'($urandom);
    t.rw    = 5'($urandom_range(0, 31));
    t.waits = $urandom_range(0, 3);
    t.noAck = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  function automatic bit misalignedM(input instr_t t);
`ifdef MEM_UNALIGNED_EXC_EN
    if (t.size == 2'd1) return (t.addr % 2) != 0;
    if (t.size >= 2'd2) return (t.addr % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] beM(input instr_t t);
    int unsigned o;
    o = t.addr % 4;
    if (t.size == 2'd0) return 4'(1 << o);
    if (t.size == 2'd1) return 4'(3 << (2 * (o / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdataM(input instr_t t);
    if (t.size == 2'd0) return 32'((t.data % 256) * 32'h0101_0101);
    if (t.size == 2'd1) return 32'((t.data % 65536) * 32'h0001_0001);
    return t.data;
  endfunction

  function automatic logic [31:0] loadM(input instr_t t);
    int unsigned o;
    int unsigned v;
    o = t.addr % 4;
    if (t.size == 2'd0) begin
      v = (t.rdata >> (8 * o)) % 256;
      if (t.sgn && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (t.size == 2'd1) begin
      v = (t.rdata >> (16 * (o / 2))) % 65536;
      if (t.sgn && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return t.rdata;
  endfunction

  task automatic driveEx(input instr_t t);
    EX_Valid = t.valid; EX_AluOut = t.addr; EX_StoreData = t.data;
    EX_MemRd = t.rd; EX_MemWr = t.wr; EX_LsSize = t.size; EX_LoadSigned = t.sgn;
    EX_PcAddOne = t.pc; EX_WbSel = t.wb; EX_Rw = t.rw; EX_Instr = t.instr; EX_RfWr = t.rfwr;
  endtask

  function automatic logic allOutputsOr();
    return |{MEM_Stall, MEM_AluOut, MEM_LTypeDmOut, MEM_PcAddOne, MEM_WbSel, MEM_Rw, MEM_Instr,
             MEM_RfWr, MEM_Exc, MEM_BusErr, dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata};
  endfunction

  // t is already on EX; it is captured at the next edge and nxt replaces it on EX right away.
  task automatic runOne(input instr_t t, input instr_t nxt);
    bit isMem, mis, acc;
    int stallCycles;
    isMem = t.valid && (t.rd || t.wr);
    mis   = isMem && misalignedM(t);
    acc   = isMem && !mis;
    stallCycles = 0;
    dbus_ack   = 1'($urandom_range(0, 1));
    dbus_rdata = $urandom;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check("aluOut", MEM_AluOut, t.addr);
    check("pcAddOne", MEM_PcAddOne, t.pc);
    check("wbSel", MEM_WbSel, t.wb);
    check("rw", MEM_Rw, t.rw);
    check("instr", MEM_Instr, t.instr);
    check("busErrQuiet", MEM_BusErr, 0);
    check("exc", MEM_Exc, mis);
    check("dmHold", MEM_LTypeDmOut, lastLoad);
    driveEx(nxt);
    if (!acc) begin
      check("reqIdle", dbus_req, 0);
      check("stallIdle", MEM_Stall, 0);
      check("rfWrPass", MEM_RfWr, t.valid && t.rfwr && !isMem);
    end else begin
      check("req", dbus_req, 1);
      check("addr", dbus_addr, {t.addr[31:2], 2'b00});
      check("we", dbus_we, t.wr);
      check("be", dbus_be, beM(t));
      if (t.wr) check("wdata", dbus_wdata, wdataM(t));
      check("rfWrBusy", MEM_RfWr, 0);
      if (MEM_Stall) stallCycles++;
      if (t.noAck) begin
        for (int c = 1; c < TMO; c++) begin
          @(posedge clk); #1;
          if (MEM_Stall) stallCycles++;
        end
        check("reqBeforeTimeout", dbus_req, 1);
        @(posedge clk); #1;
        check("reqTimeout", dbus_req, 0);
        check("stallTimeout", MEM_Stall, 0);
        check("busErrPulse", MEM_BusErr, 1);
        check("rfWrTimeout", MEM_RfWr, 0);
        check("stallCountTimeout", stallCycles, TMO);
      end else begin
        repeat (t.waits) begin
          @(posedge clk); #1;
          if (MEM_Stall) stallCycles++;
        end
        dbus_ack   = 1'b1;
        dbus_rdata = t.rdata;
        @(posedge clk); #1;
        dbus_ack   = 1'b0;
        dbus_rdata = $urandom;
        if (t.rd && !t.wr) lastLoad = loadM(t);
        check("reqDone", dbus_req, 0);
        check("stallDone", MEM_Stall, 0);
        check("rfWrDone", MEM_RfWr, t.rfwr);
        check("loadData", MEM_LTypeDmOut, lastLoad);
        check("busErrDone", MEM_BusErr, 0);
        check("stallCount", stallCycles, t.waits + 1);
        check("aluOutKept", MEM_AluOut, t.addr);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t, bubble;
    bubble = randInstr();
    bubble.valid = 1'b0; bubble.rd = 1'b0; bubble.wr = 1'b0; bubble.rfwr = 1'b0;
    bubble.addr = '0; bubble.data = '0; bubble.instr = '0; bubble.pc = '0;
    bubble.wb = '0; bubble.rw = '0; bubble.size = '0; bubble.sgn = 1'b0;

    #7;
    check("resetOutputs", allOutputsOr(), 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during BUSY, then a stray ack after reset.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b1; t.wr = 1'b0; t.size = 2'd2; t.addr = 32'h0000_5000;
    driveEx(t);
    @(posedge clk); #1;
    check("reqBeforeReset", dbus_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("reqAsyncDrop", dbus_req, 0);
    check("resetMidAccess", allOutputsOr(), 0);
    driveEx(bubble);
    dbus_ack = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dbus_ack = 1'b0;
    check("strayAckNoChange", allOutputsOr(), 0);

    // LB signed at 0x1003 with three wait states.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b1; t.wr = 1'b0; t.size = 2'd0; t.sgn = 1'b1; t.rfwr = 1'b1;
    t.addr = 32'h0000_1003; t.rdata = 32'h80FF_FF7F; t.waits = 3; t.noAck = 1'b0;
    prog.push_back(t);
    // SH at 0x2002, ack in the first BUSY cycle.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b0; t.wr = 1'b1; t.size = 2'd1; t.rfwr = 1'b0;
    t.addr = 32'h0000_2002; t.data = 32'h1234_ABCD; t.waits = 0; t.noAck = 1'b0;
    prog.push_back(t);
    // LW followed back-to-back by an ALU op.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b1; t.wr = 1'b0; t.size = 2'd2; t.rfwr = 1'b1;
    t.addr = 32'h0000_4000; t.waits = 2; t.noAck = 1'b0;
    prog.push_back(t);
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b0; t.wr = 1'b0; t.rfwr = 1'b1;
    prog.push_back(t);
    // Misaligned LW.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b1; t.wr = 1'b0; t.size = 2'd2; t.rfwr = 1'b1;
    t.addr = 32'h0000_3001; t.waits = 1; t.noAck = 1'b0;
    prog.push_back(t);
    // Bus timeout.
    t = randInstr();
    t.valid = 1'b1; t.rd = 1'b1; t.wr = 1'b0; t.size = 2'd2; t.rfwr = 1'b1;
    t.addr = 32'h0000_6000; t.noAck = 1'b1;
    prog.push_back(t);
    // Bubble that looks like a load.
    t = randInstr();
    t.valid = 1'b0; t.rd = 1'b1; t.rfwr = 1'b1;
    prog.push_back(t);
    repeat (60) prog.push_back(randInstr());

    driveEx(prog[0]);
    for (int i = 0; i < prog.size(); i++) begin
      runOne(prog[i], (i + 1 < prog.size()) ? prog[i + 1] : bubble);
      if (i == 0) check("lbSignedValue", MEM_LTypeDmOut, 32'hFFFF_FF80);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end
endmodule
